// File: rtl/apb_pkg.sv
// APB request/response bundles exchanged with the slave.
package apb_pkg;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] pwdata;
  } apb_req_s;

  typedef struct packed {
    logic        pready;
    logic [15:0] prdata;
    logic        pslverr;
  } apb_resp_s;

endpackage

// File: rtl/fsm_pkg.sv
// Network-interface controller states.
package fsm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    APB_SETUP,
    APB_ACCESS,
    RESP
  } ni_state_e;

endpackage

// File: rtl/ni_pkg.sv
// Network-interface packet constants and the request packet layout.
package ni_pkg;

  localparam int FLIT_W      = 16;
  localparam int TOTAL_FLITS = 4;

  // Head flit, TOTAL_FLITS-2 body flits (paddr, pwdata, ...), tail tag.
  typedef struct packed {
    logic [FLIT_W-1:0]                    head_flit;
    logic [TOTAL_FLITS-3:0][FLIT_W-1:0]   body_flit;
    logic [FLIT_W-1:0]                    tail_flit;
  } req_packet_s;

endpackage

// File: rtl/apb_master.sv
// APB phase driver: turns the controller's SETUP/ACCESS phases into bus
// signals and latches the slave's read data and error on completion.
module apb_master
  import apb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        setup,
  input  logic        access,
  input  logic        write,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output apb_req_s    apb_req,
  input  apb_resp_s   apb_resp,
  output logic        done,
  output logic [15:0] rdata,
  output logic        slverr
);

  // Bus signals follow the phase; address/data are zero outside a transfer.
  always_comb begin
    apb_req = '0;
    if (setup || access) begin
      apb_req.psel    = 1'b1;
      apb_req.penable = access;
      apb_req.pwrite  = write;
      apb_req.paddr   = addr;
      apb_req.pwdata  = wdata;
    end
  end

  // The transfer completes on the ACCESS edge where the slave is ready.
  assign done = access && apb_resp.pready;

  // Capture read data and error status on the completing edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      slverr <= 1'b0;
    end else if (done) begin
      rdata  <= apb_resp.prdata;
      slverr <= apb_resp.pslverr;
    end
  end

endmodule

// File: rtl/top.sv
// NoC-to-APB network interface: receives a request packet, runs one APB
// transfer, and returns a response packet.
// Handshake: a request flit moves on a rising edge where enable and ready are
// both 1; response flits are presented with valid_out=1 and no backpressure.
// TOTAL_FLITS must be at least 4 (head, paddr, pwdata, tail).
module top
  import ni_pkg::*;
  import apb_pkg::*;
  import fsm_pkg::*;
#(
  parameter int TOTAL_FLITS = ni_pkg::TOTAL_FLITS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] i_flit,
  input  logic              enable,
  output logic              ready,
  output logic [FLIT_W-1:0] o_flit,
  output logic              valid_out,
  output apb_req_s          apb_req_signals,
  input  apb_resp_s         apb_resp_signals
);

  localparam int CNT_W = $clog2(TOTAL_FLITS);
  localparam logic [CNT_W-1:0] RX_TAIL_IDX = CNT_W'(TOTAL_FLITS - 2);
  localparam logic [CNT_W-1:0] TX_LAST_IDX = CNT_W'(TOTAL_FLITS - 1);

  ni_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              write_q;
  logic [5:0]        dest_q, src_q;
  logic [FLIT_W-1:0] body_q [TOTAL_FLITS-2];
  logic [FLIT_W-1:0] tag_q;

  logic              capture;
  logic              apb_done;
  logic [15:0]       rdata;
  logic              slverr;

  assign ready   = (state_q == IDLE) || (state_q == RECV);
  assign capture = enable && ready;

  // State and flit counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: the counter indexes body/tail on receive and flits on send.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = RECV;
          cnt_d   = '0;
        end
      end
      RECV: begin
        if (capture) begin
          if (cnt_q == RX_TAIL_IDX) begin
            state_d = APB_SETUP;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      APB_SETUP: state_d = APB_ACCESS;
      APB_ACCESS: begin
        if (apb_done) begin
          state_d = RESP;
          cnt_d   = '0;
        end
      end
      RESP: begin
        if (cnt_q == TX_LAST_IDX) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Request packet capture; reserved head bits are not kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      dest_q  <= '0;
      src_q   <= '0;
      tag_q   <= '0;
      for (int k = 0; k < TOTAL_FLITS - 2; k++) body_q[k] <= '0;
    end else if (capture) begin
      if (state_q == IDLE) begin
        write_q <= i_flit[15];
        dest_q  <= i_flit[11:6];
        src_q   <= i_flit[5:0];
      end else if (cnt_q == RX_TAIL_IDX) begin
        tag_q <= i_flit;
      end else begin
        for (int k = 0; k < TOTAL_FLITS - 2; k++)
          if (cnt_q == CNT_W'(k)) body_q[k] <= i_flit;
      end
    end
  end

  apb_master u_apb_master (
    .clk      (clk),
    .reset    (reset),
    .setup    (state_q == APB_SETUP),
    .access   (state_q == APB_ACCESS),
    .write    (write_q),
    .addr     (body_q[0]),
    .wdata    (body_q[1]),
    .apb_req  (apb_req_signals),
    .apb_resp (apb_resp_signals),
    .done     (apb_done),
    .rdata    (rdata),
    .slverr   (slverr)
  );

  // Response flit mux: head with swapped ids, body (read data replaces
  // body1 on reads), then the request tag; zero when not sending.
  always_comb begin
    valid_out = (state_q == RESP);
    o_flit    = '0;
    if (valid_out) begin
      if (cnt_q == '0) begin
        o_flit = {write_q, slverr, 2'b00, src_q, dest_q};
      end else if (cnt_q == TX_LAST_IDX) begin
        o_flit = tag_q;
      end else begin
        for (int k = 0; k < TOTAL_FLITS - 2; k++)
          if (cnt_q == CNT_W'(k + 1))
            o_flit = (k == 1 && !write_q) ? rdata : body_q[k];
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the NoC-to-APB network interface.
module tb_top;
  import apb_pkg::*;

  localparam int TF = 4;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_flit;
  logic        enable;
  logic        ready;
  logic [15:0] o_flit;
  logic        valid_out;
  apb_req_s    apb_req;
  apb_resp_s   apb_resp = '0;

  always #5 clk = ~clk;

  top #(.TOTAL_FLITS(TF)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_flit           (i_flit),
    .enable           (enable),
    .ready            (ready),
    .o_flit           (o_flit),
    .valid_out        (valid_out),
    .apb_req_signals  (apb_req),
    .apb_resp_signals (apb_resp)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          waits;
  } apb_exp_t;
  apb_exp_t apb_q[$];

  int resp_pkts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    tests++;
    fails++;
    $display("FAIL %s: got 0x%0h, required no such event", name, act);
  endtask

  // ---------------- APB slave responder ----------------
  int          cfg_waits  = 0;
  logic [15:0] cfg_prdata = '0;
  logic        cfg_err    = 1'b0;
  int          acc_cnt    = 0;

  always @(posedge clk) begin
    #1;
    if (apb_req.psel && apb_req.penable) acc_cnt++;
    else acc_cnt = 0;
    apb_resp.pready  = apb_req.psel && apb_req.penable && (acc_cnt >= cfg_waits + 1);
    apb_resp.prdata  = cfg_prdata;
    apb_resp.pslverr = cfg_err;
  end

  // ---------------- monitor ----------------
  int       resp_idx  = 0;
  int       acc_seen  = 0;
  logic     have_cur  = 1'b0;
  logic     prev_setup = 1'b0;
  apb_exp_t cur;

  always @(negedge clk) begin
    if (reset) begin
      resp_idx   = 0;
      have_cur   = 1'b0;
      prev_setup = 1'b0;
    end else begin
      // response side
      if (valid_out) begin
        if (exp_q.size() == 0) fail_now("unexpected_resp_flit", o_flit);
        else chk("resp_flit", o_flit, exp_q.pop_front());
        chk("ready_low_in_resp", ready, 1'b0);
        resp_idx++;
        if (resp_idx == TF) begin
          resp_idx = 0;
          resp_pkts++;
        end
      end else begin
        chk("o_flit_zero_when_idle", o_flit, 16'h0000);
        if (resp_idx != 0) fail_now("resp_gap", resp_idx);
        resp_idx = 0;
      end
      // APB side
      if (prev_setup && !(apb_req.psel && apb_req.penable))
        fail_now("access_after_setup", {apb_req.psel, apb_req.penable});
      prev_setup = 1'b0;
      if (apb_req.psel && !apb_req.penable) begin
        prev_setup = 1'b1;
        chk("ready_low_in_apb", ready, 1'b0);
        if (apb_q.size() == 0) begin
          fail_now("unexpected_apb_setup", apb_req.paddr);
          have_cur = 1'b0;
        end else begin
          cur = apb_q.pop_front();
          chk("setup_pwrite", apb_req.pwrite, cur.w);
          chk("setup_paddr", apb_req.paddr, cur.a);
          chk("setup_pwdata", apb_req.pwdata, cur.d);
          acc_seen = 0;
          have_cur = 1'b1;
        end
      end else if (apb_req.psel && apb_req.penable) begin
        acc_seen++;
        if (have_cur) begin
          chk("access_held_paddr", apb_req.paddr, cur.a);
          chk("access_held_pwdata", apb_req.pwdata, cur.d);
          chk("access_held_pwrite", apb_req.pwrite, cur.w);
          if (apb_resp.pready) begin
            chk("access_cycles", acc_seen, cur.waits + 1);
            have_cur = 1'b0;
          end
        end else begin
          fail_now("access_without_setup", apb_req.paddr);
        end
      end else if (apb_req.penable) begin
        fail_now("penable_without_psel", apb_req.penable);
      end
    end
  end

  // ---------------- reference model ----------------
  // Response rules: ids swapped, write and error flags in head, body1 is
  // the slave's read data for reads and the written data for writes.
  task automatic push_expected(input logic w, input logic [5:0] dest, input logic [5:0] src,
                               input logic [15:0] addr, input logic [15:0] wdata,
                               input logic [15:0] tag, input logic [15:0] prdata,
                               input logic err, input int waits);
    apb_exp_t e;
    e.w = w; e.a = addr; e.d = wdata; e.waits = waits;
    apb_q.push_back(e);
    exp_q.push_back({w, err, 2'b00, src, dest});
    exp_q.push_back(addr);
    exp_q.push_back(w ? wdata : prdata);
    exp_q.push_back(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_flit(input logic [15:0] f);
    int guard;
    guard = 0;
    @(negedge clk);
    i_flit = f;
    enable = 1'b1;
    while (!ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) fail_now("put_flit_timeout", f);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      enable = 1'b0;
      i_flit = 16'($urandom);
    end
  endtask

  // Wait for the interface to accept again; optionally offer junk flits
  // while it is busy, none of which may be taken.
  task automatic wait_ready(input logic junk);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      if (junk && !ready) begin
        enable = 1'b1;
        i_flit = 16'($urandom);
      end else begin
        enable = 1'b0;
      end
      guard++;
    end while (!ready && guard < 500);
    if (!ready) fail_now("ready_timeout", guard);
    enable = 1'b0;
  endtask

  task automatic send_pkt(input logic w, input logic [5:0] dest, input logic [5:0] src,
                          input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [15:0] tag, input int waits,
                          input logic [15:0] prdata, input logic err,
                          input int gap, input logic junk);
    int target;
    cfg_waits  = waits;
    cfg_prdata = prdata;
    cfg_err    = err;
    push_expected(w, dest, src, addr, wdata, tag, prdata, err, waits);
    target = resp_pkts + 1;
    put_flit({w, 3'b000, dest, src});
    put_flit(addr);
    idle(gap);
    put_flit(wdata);
    idle(gap);
    put_flit(tag);
    wait_ready(junk);
    chk("resp_packet_count", resp_pkts, target);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    enable = 1'b0;
    reset  = 1'b1;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    reset  = 1'b1;
    enable = 1'b0;
    i_flit = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("reset_ready", ready, 1'b1);
    chk("reset_valid_out", valid_out, 1'b0);
    chk("reset_o_flit", o_flit, 16'h0000);
    chk("reset_psel", apb_req.psel, 1'b0);
    chk("reset_penable", apb_req.penable, 1'b0);
    chk("reset_pwrite", apb_req.pwrite, 1'b0);
    chk("reset_paddr", apb_req.paddr, 16'h0000);
    chk("reset_pwdata", apb_req.pwdata, 16'h0000);

    // write: 0x8042 0x0010 0xBEEF 0x00A5 -> 0x8081 0x0010 0xBEEF 0x00A5
    send_pkt(1'b1, 6'd1, 6'd2, 16'h0010, 16'hBEEF, 16'h00A5, 0, 16'h5555, 1'b0, 0, 1'b0);
    // read: 0x0042 0x0020 0x0000 0x0011, prdata 0x1234
    send_pkt(1'b0, 6'd1, 6'd2, 16'h0020, 16'h0000, 16'h0011, 0, 16'h1234, 1'b0, 0, 1'b0);
    // three wait states
    send_pkt(1'b0, 6'd1, 6'd2, 16'h0030, 16'h0000, 16'h0022, 3, 16'hCAFE, 1'b0, 0, 1'b0);
    // slave error on a write -> head 0xC081
    send_pkt(1'b1, 6'd1, 6'd2, 16'h0010, 16'hBEEF, 16'h00A5, 0, 16'h0000, 1'b1, 0, 1'b0);
    // gaps between body flits and junk offered while busy
    send_pkt(1'b1, 6'd1, 6'd2, 16'h0010, 16'hBEEF, 16'h00A5, 1, 16'h0000, 1'b0, 2, 1'b1);

    // reset in the middle of receiving: nothing may follow
    put_flit(16'h8042);
    put_flit(16'h0010);
    pulse_reset();
    repeat (12) @(negedge clk);
    chk("abort_recv_ready", ready, 1'b1);
    chk("abort_recv_psel", apb_req.psel, 1'b0);
    send_pkt(1'b1, 6'd1, 6'd2, 16'h0010, 16'hBEEF, 16'h00A5, 0, 16'h0000, 1'b0, 0, 1'b0);

    // reset in the middle of an APB access: no response may follow
    cfg_waits = 30;
    push_expected(1'b0, 6'd3, 6'd4, 16'h0040, 16'h0000, 16'h0033, 16'h7777, 1'b0, 30);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    put_flit({1'b0, 3'b000, 6'd3, 6'd4});
    put_flit(16'h0040);
    put_flit(16'h0000);
    put_flit(16'h0033);
    idle(1);
    guard = 0;
    while (!(apb_req.psel && apb_req.penable) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!(apb_req.psel && apb_req.penable)) fail_now("access_never_started", guard);
    repeat (3) @(negedge clk);
    pulse_reset();
    repeat (45) @(negedge clk);
    chk("abort_apb_queue_empty", apb_q.size(), 0);
    chk("abort_apb_ready", ready, 1'b1);

    // randomized traffic
    for (int i = 0; i < 20; i++) begin
      send_pkt(1'($urandom_range(0, 1)), 6'($urandom), 6'($urandom),
               16'($urandom), 16'($urandom), 16'($urandom),
               $urandom_range(0, 3), 16'($urandom),
               ($urandom_range(0, 3) == 0), $urandom_range(0, 2),
               1'($urandom_range(0, 1)));
    end

    idle(5);
    chk("final_resp_queue_empty", exp_q.size(), 0);
    chk("final_apb_queue_empty", apb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time limit.
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all logic is on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port i_flit, input, 16 bits: request flit from NoC.
REQ-004 SHALL have port enable, input, 1 bit: i_flit valid this cycle.
REQ-005 SHALL have port ready, output, 1 bit: NI can accept request flits.
REQ-006 SHALL have port o_flit, output, 16 bits: response flit to NoC.
REQ-007 SHALL have port valid_out, output, 1 bit: o_flit valid this cycle.
REQ-008 SHALL have port apb_req_signals, output, apb_req_s: {psel, penable, pwrite, paddr[15:0], pwdata[15:0]}.
REQ-009 SHALL have port apb_resp_signals, input, apb_resp_s: {pready, prdata[15:0], pslverr}.
REQ-010 SHALL use parameter TOTAL_FLITS, default 4, meaning flits per packet (head, TOTAL_FLITS-2 body, tail).

Function
REQ-011 SHALL define the request head as: [15] write, [14:12] reserved, [11:6] dest id, [5:0] src id.
REQ-012 SHALL define the request packet as: body_flit[0] = paddr, body_flit[1] = pwdata (ignored for reads), tail = 16-bit tag.
REQ-013 SHALL have FSM states IDLE, RECV, APB_SETUP, APB_ACCESS, RESP.
REQ-014 SHALL capture a flit on a rising edge only when enable=1 and ready=1.
REQ-015 SHALL drive ready=1 only in IDLE and RECV; enable is ignored in all other states.
REQ-016 SHALL handle receive as: IDLE -> RECV on head capture; a flit counter indexes body and tail; tail capture -> APB_SETUP.
REQ-017 SHALL hold the counter and state when enable=0 mid-packet (gaps allowed).
REQ-018 SHALL, in APB_SETUP, drive psel=1, penable=0 for exactly one cycle, with paddr, pwrite and pwdata from the packet, then go to APB_ACCESS.
REQ-019 SHALL, in APB_ACCESS, drive psel=1, penable=1 and hold address/data stable until pready=1.
REQ-020 SHALL, on the edge where pready=1, register prdata and pslverr, deassert psel/penable the next cycle, and go to RESP.
REQ-021 SHALL wait indefinitely for pready; there is no timeout.
REQ-022 SHALL, in RESP, emit TOTAL_FLITS flits on consecutive cycles with valid_out=1 and no backpressure, then return to IDLE.
REQ-023 SHALL form the response head as: [15] write, [14] pslverr, [13:12] 0, [11:6] = request src, [5:0] = request dest.
REQ-024 SHALL form the response body as: body0 = paddr; body1 = registered prdata for reads or echoed pwdata for writes; tail = request tag.
REQ-025 SHALL drive o_flit=0 whenever valid_out=0.
REQ-026 SHALL allow the earliest next head capture on the cycle after the last response flit.

Reset
REQ-027 SHALL, on reset, set state to IDLE, clear the counter, and set ready=1, valid_out=0, o_flit=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0.
REQ-028 SHALL, on reset mid-packet or mid-APB transfer, abort the transaction: no APB access and no response are produced afterwards.

Structure
REQ-029 SHALL place FLIT_W=16, TOTAL_FLITS and req_packet_s {head_flit, body_flit[TOTAL_FLITS-2], tail_flit} in ni_pkg.
REQ-030 SHALL place apb_req_s and apb_resp_s in apb_pkg.
REQ-031 SHALL place the FSM state enum in fsm_pkg.
REQ-032 SHALL implement the APB SETUP/ACCESS sequencing in one sub-module, apb_master; flit receive/transmit stays in top.

Verification
REQ-033 SHALL cover write: flits 0x8042, 0x0010, 0xBEEF, 0x00A5 with pready=1 -> one SETUP then one ACCESS cycle with pwrite=1, paddr=0x0010, pwdata=0xBEEF; response flits 0x8081, 0x0010, 0xBEEF, 0x00A5.
REQ-034 SHALL cover read: flits 0x0042, 0x0020, 0x0000, 0x0011 with prdata=0x1234 -> pwrite=0; response flits 0x0081, 0x0020, 0x1234, 0x0011.
REQ-035 SHALL cover wait states: pready low for 3 ACCESS cycles -> psel/penable and paddr held for 4 ACCESS cycles; response sent only after pready.
REQ-036 SHALL cover error: write with pslverr=1 -> response head 0xC081.
REQ-037 SHALL cover gaps and lockout: enable low 2 cycles between body flits -> same result as the gapless case; flits offered during APB or RESP states are not captured.
REQ-038 SHALL cover reset mid-RECV: after reset, no APB activity occurs; a fresh packet then completes normally.
